// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

  localparam int unsigned HZ_REG_W = 5;

  typedef logic [HZ_REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalted  = 2'd2
  } hz_state_t;

  localparam int unsigned HZ_STATES = 3;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: flags a load in EX whose destination feeds the instruction in ID.
// Register 0 is hard-wired to zero, so it never creates a dependency.
module hazard_cmp #(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  output logic             load_use
);

  // Match either source against the load destination, masking r0.
  always_comb begin
    load_use = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stalls, bubbles and flushes for the 5-stage datapath.
// Optional statistics counters are built when HAZARD_STATS_EN is defined; otherwise the
// counter ports are tied to zero.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             mem_dreq,
  input  logic             dhit,
  input  logic             ihit,
  input  logic             mem_branch,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t state_q, state_d;
  logic      load_use;
  logic      branch_fire;

  hazard_cmp #(
    .REG_W(REG_W)
  ) u_cmp (
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .ex_rd     (ex_rd),
    .ex_memread(ex_memread),
    .load_use  (load_use)
  );

  // State register; reset drops straight back to RUN from any state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority decode of enables/flushes and next state.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    branch_fire = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      StRun: begin
        if (wb_halt) begin
          // Let the halt retire through WB, freeze everything upstream.
          memwb_en = 1'b1;
          state_d  = StHalted;
        end else if (mem_dreq && !dhit) begin
          state_d = StMemWait;
        end else if (mem_branch) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
          branch_fire = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID, inject one bubble into EX.
          {idex_en, exmem_en, memwb_en} = 3'b111;
          idex_flush = 1'b1;
        end else if (!ihit) begin
          // Fetch not ready: push a bubble into ID, let the rest drain.
          {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
          ifid_flush = 1'b1;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        end
      end
      StMemWait: begin
        // WB is frozen here, so wb_halt is deliberately ignored.
        if (dhit) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          state_d = StRun;
          if (mem_branch) begin
            {ifid_flush, idex_flush, exmem_flush} = 3'b111;
            branch_fire = 1'b1;
          end
        end
      end
      StHalted: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CntOne = 1;

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Event counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && (state_q != StHalted)) begin
        stall_cnt_q <= stall_cnt_q + CntOne;
      end
      if (branch_fire) begin
        flush_cnt_q <= flush_cnt_q + CntOne;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
